// File: rtl/cevero_data_mem_resp.sv
// cevero_data_mem_resp: req/gnt/rvalid data-memory responder with grant stall, range errors and a saturating error counter.
// Optional byte parity with fault injection is compiled in when CEVERO_MEM_PARITY_EN is defined.
module cevero_data_mem_resp #(
    parameter int unsigned NUM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned GNT_DELAY = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic [15:0] err_count_o
`ifdef CEVERO_MEM_PARITY_EN
    ,
    input  logic        fault_flip_i
`endif
);
    localparam int AW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;

    typedef enum logic {S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   cnt, cnt_d;
    logic [32:0]   addr_x, lo, hi, off;
    logic          in_range, wr_en, resp_err, par_bad;
    logic [AW-1:0] idx;
    logic [31:0]   mem [NUM_WORDS];
    logic [31:0]   rd_word;

    // 33-bit decode so the top of the window never wraps
    assign addr_x   = {1'b0, data_addr_i};
    assign lo       = {1'b0, BASE_ADDR};
    assign hi       = lo + (33'(NUM_WORDS) << 2);
    assign in_range = (addr_x >= lo) && (addr_x < hi);
    assign off      = addr_x - lo;
    assign idx      = off[AW+1:2];
    assign rd_word  = mem[idx];
    assign wr_en    = data_gnt_o && data_we_i && in_range;
    assign resp_err = !in_range || (!data_we_i && par_bad);
    assign data_rvalid_o = state_q == S_RESP;

    // Grant decision, stall counter update and next state
    always_comb begin
        data_gnt_o = data_req_i && !rst_i && (cnt == GNT_DELAY);
        state_d    = data_gnt_o ? S_RESP : S_WAIT;
        cnt_d      = (data_gnt_o || !data_req_i) ? 32'd0 : (cnt < GNT_DELAY ? cnt + 32'd1 : cnt);
    end

    // State, stall counter, response registers and saturating error count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_WAIT;
            cnt          <= 32'd0;
            data_rdata_o <= 32'h0;
            data_err_o   <= 1'b0;
            err_count_o  <= 16'h0;
        end else begin
            state_q <= state_d;
            cnt     <= cnt_d;
            if (data_gnt_o) begin
                data_rdata_o <= (in_range && !data_we_i) ? rd_word : 32'h0;
                data_err_o   <= resp_err;
                if (resp_err && err_count_o != 16'hFFFF)
                    err_count_o <= err_count_o + 16'd1;
            end
        end
    end

    // Byte-masked array write at the grant edge; the array itself is never reset
    always_ff @(posedge clk_i) begin
        for (int n = 0; n < 4; n++)
            if (wr_en && data_be_i[n])
                mem[idx][8*n +: 8] <= data_wdata_i[8*n +: 8];
    end

`ifdef CEVERO_MEM_PARITY_EN
    logic [3:0] par [NUM_WORDS];
    logic [3:0] calc_par;

    // Recompute even parity of the stored word and compare with the stored bits
    always_comb begin
        calc_par = {^rd_word[31:24], ^rd_word[23:16], ^rd_word[15:8], ^rd_word[7:0]};
        par_bad  = in_range && (par[idx] != calc_par);
    end

    // Parity written alongside each enabled byte; fault_flip_i inverts it for injection
    always_ff @(posedge clk_i) begin
        for (int n = 0; n < 4; n++)
            if (wr_en && data_be_i[n])
                par[idx][n] <= (^data_wdata_i[8*n +: 8]) ^ fault_flip_i;
    end
`else
    assign par_bad = 1'b0;
`endif

endmodule

// File: tb/tb_cevero_data_mem_resp.sv
// tb_cevero_data_mem_resp: directed and random checks of the data-memory responder against a word-level model.
module tb_cevero_data_mem_resp;
    logic        clk = 1'b0;
    logic        rst;
    logic        req, we, gnt, rvalid, err;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic [15:0] errcnt;
    logic        req2, gnt2, rvalid2, err2;
    logic [31:0] rdata2;
    logic [15:0] errcnt2;
    logic        flip;

    int n_asrt = 0;
    int n_fail = 0;
    logic [31:0] mem_m [int];
    logic [3:0]  pbad_m [int];
    int err_m = 0;
    int wl [8] = '{0, 1, 2, 3, 4, 5, 1022, 1023};

    always #5 clk = ~clk;

    cevero_data_mem_resp #(.NUM_WORDS(1024), .BASE_ADDR(32'h0), .GNT_DELAY(0)) dut (
        .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt), .data_rvalid_o(rvalid),
        .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
        .data_rdata_o(rdata), .data_err_o(err), .err_count_o(errcnt)
`ifdef CEVERO_MEM_PARITY_EN
        , .fault_flip_i(flip)
`endif
    );

    cevero_data_mem_resp #(.NUM_WORDS(1024), .BASE_ADDR(32'h0), .GNT_DELAY(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req2), .data_gnt_o(gnt2), .data_rvalid_o(rvalid2),
        .data_we_i(1'b1), .data_be_i(4'h0), .data_addr_i(32'h0), .data_wdata_i(32'h0),
        .data_rdata_o(rdata2), .data_err_o(err2), .err_count_o(errcnt2)
`ifdef CEVERO_MEM_PARITY_EN
        , .fault_flip_i(1'b0)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on the zero-stall instance, starting and ending at a falling edge
    task automatic xact(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d, input logic f);
        logic        inr = a < 32'h1000;
        int          i = int'(a[31:2]);
        logic [31:0] t, exp_rd = 32'h0;
        logic        known = 1'b1;
        logic        exp_err = !inr;
        if (inr && w) begin
            t = mem_m.exists(i) ? mem_m[i] : 32'h0;
            if (!pbad_m.exists(i)) pbad_m[i] = 4'h0;
            for (int n = 0; n < 4; n++)
                if (b[n]) begin
                    t[8*n +: 8] = d[8*n +: 8];
                    pbad_m[i][n] = f;
                end
            mem_m[i] = t;
        end else if (inr) begin
            known = mem_m.exists(i);
            if (known) begin
                exp_rd = mem_m[i];
                exp_err = pbad_m[i] != 4'h0;
            end
        end
        if (exp_err && known && err_m < 65535) err_m++;
        req = 1'b1; we = w; be = b; addr = a; wdata = d; flip = f;
        #1 chk("gnt_same_cycle", {31'b0, gnt}, 32'd1);
        @(posedge clk);
        #1 req = 1'b0;
        chk("rvalid_next_cycle", {31'b0, rvalid}, 32'd1);
        if (known) begin
            chk("rdata", rdata, exp_rd);
            chk("err", {31'b0, err}, {31'b0, exp_err});
            chk("err_count", {16'b0, errcnt}, 32'(err_m));
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0; flip = 1'b0; req2 = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1 chk("rst_gnt", {31'b0, gnt}, 32'd0);
            chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
            chk("rst_rdata", rdata, 32'h0);
        end
        @(negedge clk) rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1 chk("idle_gnt", {31'b0, gnt}, 32'd0);
            chk("idle_rvalid", {31'b0, rvalid}, 32'd0);
            chk("idle_err", {31'b0, err}, 32'd0);
            chk("idle_err_count", {16'b0, errcnt}, 32'd0);
            chk("idle_rvalid2", {31'b0, rvalid2}, 32'd0);
        end
        @(negedge clk);
        xact(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
        xact(1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
        xact(1'b1, 4'b0101, 32'h10, 32'h11223344, 1'b0);
        chk("be_model", mem_m[4], 32'hDE22BE44);
        xact(1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
        xact(1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 1'b0);
        xact(1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
        xact(1'b1, 4'hF, 32'h0, 32'h0BADF00D, 1'b0);
        // Back-to-back reads with req held high
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h10;
        #1 chk("b2b_gnt0", {31'b0, gnt}, 32'd1);
        @(posedge clk);
        #1 chk("b2b_rvalid0", {31'b0, rvalid}, 32'd1);
        chk("b2b_rdata0", rdata, 32'hDE22BE44);
        addr = 32'h0;
        #1 chk("b2b_gnt1", {31'b0, gnt}, 32'd1);
        @(posedge clk);
        #1 chk("b2b_rvalid1", {31'b0, rvalid}, 32'd1);
        chk("b2b_rdata1", rdata, 32'h0BADF00D);
        req = 1'b0;
        @(posedge clk);
        #1 chk("b2b_rvalid_end", {31'b0, rvalid}, 32'd0);
        @(negedge clk);
        // Reset mid-response drops rvalid, and a write under reset never lands
        req = 1'b1; we = 1'b0; addr = 32'h10;
        @(posedge clk);
        #1 req = 1'b0;
        chk("pre_rst_rvalid", {31'b0, rvalid}, 32'd1);
        rst = 1'b1;
        #1 chk("async_rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("async_rst_rdata", rdata, 32'h0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h10; wdata = 32'h0;
        #1 chk("rst_write_gnt", {31'b0, gnt}, 32'd0);
        @(negedge clk);
        req = 1'b0; rst = 1'b0; err_m = 0;
        @(negedge clk);
        xact(1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
        // Range boundaries
        xact(1'b0, 4'hF, 32'h1000, 32'h0, 1'b0);
        xact(1'b1, 4'hF, 32'h1000, 32'hCAFEBABE, 1'b0);
        xact(1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
        xact(1'b1, 4'hF, 32'hFFC, 32'h12345678, 1'b0);
        xact(1'b0, 4'hF, 32'hFFF, 32'h0, 1'b0);
        xact(1'b0, 4'hF, 32'hFFFFFFFC, 32'h0, 1'b0);
`ifdef CEVERO_MEM_PARITY_EN
        xact(1'b1, 4'hF, 32'h20, 32'hA5A5A5A5, 1'b1);
        xact(1'b0, 4'hF, 32'h20, 32'h0, 1'b0);
        xact(1'b1, 4'hF, 32'h20, 32'hA5A5A5A5, 1'b0);
        xact(1'b0, 4'hF, 32'h20, 32'h0, 1'b0);
`endif
        // Grant stall of two cycles, grant clears the counter
        req2 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) req2 = 1'b0;
            #1 chk($sformatf("stall_gnt_c%0d", c), {31'b0, gnt2}, {31'b0, c == 2});
            chk($sformatf("stall_rvalid_c%0d", c), {31'b0, rvalid2}, {31'b0, c == 3});
            @(negedge clk);
        end
        req2 = 1'b1;
        #1 chk("pulse_gnt", {31'b0, gnt2}, 32'd0);
        @(negedge clk) req2 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1 chk("pulse_idle_gnt", {31'b0, gnt2}, 32'd0);
            chk("pulse_idle_rvalid", {31'b0, rvalid2}, 32'd0);
            @(negedge clk);
        end
        req2 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("restall_gnt_c%0d", c), {31'b0, gnt2}, {31'b0, c == 2});
            @(negedge clk);
        end
        req2 = 1'b0;
        @(negedge clk);
        // Random traffic against the model
        foreach (wl[k]) xact(1'b1, 4'hF, 32'(wl[k] * 4), $urandom, 1'b0);
        for (int k = 0; k < 60; k++) begin
            int r = $urandom_range(0, 9);
            logic [31:0] a;
            a = r < 8 ? 32'(wl[r] * 4) | 32'($urandom_range(0, 3))
                      : (r == 8 ? 32'h1000 + 32'($urandom_range(0, 255) * 4) : ($urandom | 32'h8000_0000));
            xact(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, 1'b0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
